// File: rtl/fifo_spi_reader.sv
// SPI mode-0 master that drains MSB-first pixel words from the fifo_spi slave,
// pacing each word on a synchronised pixel_ready and strobing word_valid per word.
module fifo_spi_reader #(
  parameter int CLK_DIV  = 4,
  parameter int WORD_W   = 16,
  parameter int CS_SETUP = 2,
  parameter int CS_HOLD  = 2,
  parameter int GAP      = 4,
  parameter int TIMEOUT  = 65535
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic              start,
  input  logic [10:0]       frame_len,
  input  logic              abort,
  input  logic              pixel_ready,
  input  logic              spi_miso,
  output logic              spi_clk,
  output logic              fifo_cs,
  output logic              spi_mosi,
  output logic [WORD_W-1:0] word_data,
  output logic              word_valid,
  output logic              busy,
  output logic              done,
  output logic              err_timeout
);

  localparam int BW = (WORD_W > 1) ? $clog2(WORD_W) : 1;
  localparam logic [7:0]    SETUP_LAST = 8'(CS_SETUP - 1);
  localparam logic [7:0]    HOLD_LAST  = 8'(CS_HOLD - 1);
  localparam logic [7:0]    GAP_LAST   = 8'(GAP - 1);
  localparam logic [7:0]    DIV_LAST   = 8'(CLK_DIV - 1);
  localparam logic [BW-1:0] BIT_LAST   = BW'(WORD_W - 1);
  localparam logic [15:0]   TO_LAST    = 16'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT_RDY, S_SETUP, S_SHIFT, S_HOLD, S_GAP, S_FINISH
  } state_t;

  state_t            state;
  logic [1:0]        rdy_sync;
  logic [7:0]        step_cnt;
  logic [BW-1:0]     bit_cnt;
  logic [15:0]       timer;
  logic [11:0]       words_left;
  logic              abort_lat;
  logic [WORD_W-1:0] shreg;

  assign spi_mosi = 1'b0;

  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      rdy_sync <= 2'b00;
    end else begin
      rdy_sync <= {rdy_sync[0], pixel_ready};
    end
  end

  // step_cnt is shared: SETUP/HOLD/GAP durations and the SCLK half-period divider.
  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      state       <= S_IDLE;
      spi_clk     <= 1'b0;
      fifo_cs     <= 1'b1;
      word_data   <= '0;
      word_valid  <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      err_timeout <= 1'b0;
      step_cnt    <= '0;
      bit_cnt     <= '0;
      timer       <= '0;
      words_left  <= '0;
      abort_lat   <= 1'b0;
      shreg       <= '0;
    end else begin
      word_valid <= 1'b0;
      done       <= 1'b0;
      if (state != S_IDLE && abort) abort_lat <= 1'b1;
      case (state)
        S_IDLE: begin
          if (start) begin
            words_left  <= (frame_len == 11'd0) ? 12'd2048 : {1'b0, frame_len};
            busy        <= 1'b1;
            err_timeout <= 1'b0;
            abort_lat   <= 1'b0;
            timer       <= '0;
            state       <= S_WAIT_RDY;
          end
        end
        S_WAIT_RDY: begin
          if (abort || abort_lat) begin
            state <= S_FINISH;
          end else if (rdy_sync[1]) begin
            fifo_cs  <= 1'b0;
            step_cnt <= '0;
            timer    <= '0;
            state    <= S_SETUP;
          end else if (timer == TO_LAST) begin
            err_timeout <= 1'b1;
            state       <= S_FINISH;
          end else begin
            timer <= timer + 16'd1;
          end
        end
        S_SETUP: begin
          if (step_cnt == SETUP_LAST) begin
            step_cnt <= '0;
            bit_cnt  <= '0;
            state    <= S_SHIFT;
          end else begin
            step_cnt <= step_cnt + 8'd1;
          end
        end
        S_SHIFT: begin
          if (step_cnt == DIV_LAST) begin
            step_cnt <= '0;
            if (!spi_clk) begin
              spi_clk <= 1'b1;
              shreg   <= {shreg[WORD_W-2:0], spi_miso};
            end else begin
              spi_clk <= 1'b0;
              if (bit_cnt == BIT_LAST) state <= S_HOLD;
              else bit_cnt <= bit_cnt + 1'b1;
            end
          end else begin
            step_cnt <= step_cnt + 8'd1;
          end
        end
        S_HOLD: begin
          if (step_cnt == HOLD_LAST) begin
            fifo_cs    <= 1'b1;
            word_data  <= shreg;
            word_valid <= 1'b1;
            words_left <= words_left - 12'd1;
            step_cnt   <= '0;
            state      <= S_GAP;
          end else begin
            step_cnt <= step_cnt + 8'd1;
          end
        end
        S_GAP: begin
          if (step_cnt == GAP_LAST) begin
            step_cnt <= '0;
            timer    <= '0;
            state    <= (words_left == 12'd0 || abort_lat) ? S_FINISH : S_WAIT_RDY;
          end else begin
            step_cnt <= step_cnt + 8'd1;
          end
        end
        S_FINISH: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_spi_reader.sv
// Directed bench for fifo_spi_reader: a default-parameter instance for word/pacing/abort/reset
// and a fast instance (TIMEOUT=100, 4-bit words) for timeout and the full 2048-word frame.
module tb_fifo_spi_reader;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic        m_start, m_abort, m_ready, m_miso, m_sclk, m_cs, m_mosi;
  logic        m_valid, m_busy, m_done, m_err;
  logic [10:0] m_len;
  logic [15:0] m_data;

  logic        f_start, f_abort, f_ready, f_miso, f_sclk, f_cs, f_mosi;
  logic        f_valid, f_busy, f_done, f_err;
  logic [10:0] f_len;
  logic [3:0]  f_data;

  fifo_spi_reader dut (
    .sys_clk(clk), .sys_rst(rst_n), .start(m_start), .frame_len(m_len), .abort(m_abort),
    .pixel_ready(m_ready), .spi_miso(m_miso), .spi_clk(m_sclk), .fifo_cs(m_cs),
    .spi_mosi(m_mosi), .word_data(m_data), .word_valid(m_valid), .busy(m_busy),
    .done(m_done), .err_timeout(m_err)
  );

  fifo_spi_reader #(.CLK_DIV(2), .WORD_W(4), .TIMEOUT(100)) dut_fast (
    .sys_clk(clk), .sys_rst(rst_n), .start(f_start), .frame_len(f_len), .abort(f_abort),
    .pixel_ready(f_ready), .spi_miso(f_miso), .spi_clk(f_sclk), .fifo_cs(f_cs),
    .spi_mosi(f_mosi), .word_data(f_data), .word_valid(f_valid), .busy(f_busy),
    .done(f_done), .err_timeout(f_err)
  );

  // Slave models: load base+index on select fall, shift on each SCLK fall.
  logic [15:0] m_sr = '0, m_idx = '0, m_base = '0;
  always @(negedge m_cs) begin m_sr = m_base + m_idx; m_idx = m_idx + 16'd1; end
  always @(negedge m_sclk) if (!m_cs) m_sr = {m_sr[14:0], 1'b0};
  assign m_miso = m_sr[15];

  logic [3:0] f_sr = '0, f_idx = '0;
  always @(negedge f_cs) begin f_sr = f_idx; f_idx = f_idx + 4'd1; end
  always @(negedge f_sclk) if (!f_cs) f_sr = {f_sr[2:0], 1'b0};
  assign f_miso = f_sr[3];

  int m_rises = 0, m_vcnt = 0, m_dcnt = 0, m_cslow = 0;
  logic [15:0] m_last = '0;
  always @(posedge m_sclk) m_rises++;
  always @(posedge clk) begin
    if (m_valid === 1'b1) begin m_vcnt++; m_last = m_data; end
    if (m_done === 1'b1) m_dcnt++;
    if (m_cs === 1'b0) m_cslow++;
  end

  // Fast slave serves a continuous 4-bit ramp, so every delivered word must be prev+1.
  int f_vcnt = 0, f_dcnt = 0, f_ord_err = 0;
  logic [3:0] f_prev = '0;
  bit f_have = 1'b0;
  always @(posedge clk) begin
    if (f_valid === 1'b1) begin
      if (f_have && f_data !== f_prev + 4'd1) f_ord_err++;
      f_prev = f_data; f_have = 1'b1; f_vcnt++;
    end
    if (f_done === 1'b1) f_dcnt++;
  end

  int n_compared = 0, n_mismatched = 0;
  int n, s_r, s_v, s_d, s_c, s_o;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    n_compared++;
    assert (observed === expected) else begin
      n_mismatched++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input bit fast, input logic [10:0] len);
    if (fast) begin f_len = len; f_start = 1'b1; end
    else begin m_len = len; m_start = 1'b1; end
    @(negedge clk);
    f_start = 1'b0;
    m_start = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    m_start = 0; m_abort = 0; m_ready = 0; m_len = '0;
    f_start = 0; f_abort = 0; f_ready = 0; f_len = '0;
    repeat (3) @(negedge clk);
    checkOutput("rst_cs", m_cs, 1);
    checkOutput("rst_sclk", m_sclk, 0);
    checkOutput("rst_busy", m_busy, 0);
    checkOutput("rst_valid", m_valid, 0);
    checkOutput("rst_done", m_done, 0);
    checkOutput("rst_err", m_err, 0);
    checkOutput("rst_data", m_data, 0);
    checkOutput("rst_mosi", m_mosi, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Single word
    m_ready = 1'b1;
    repeat (3) @(negedge clk);
    m_base = 16'hA55A - m_idx;
    s_r = m_rises; s_v = m_vcnt; s_d = m_dcnt; s_c = m_cslow;
    applyStimulus(1'b0, 11'd1);
    checkOutput("single_busy", m_busy, 1);
    n = 0;
    while (!m_valid && n < 300) begin @(negedge clk); n++; end
    checkOutput("single_valid", m_valid, 1);
    checkOutput("single_data", m_data, 16'hA55A);
    checkOutput("single_cs_at_valid", m_cs, 1);
    n = 0;
    while (!m_done && n < 20) begin @(negedge clk); n++; end
    checkOutput("valid_to_done", n, 5);
    checkOutput("single_busy_at_done", m_busy, 0);
    @(negedge clk);
    checkOutput("done_pulse", m_done, 0);
    checkOutput("single_rises", m_rises - s_r, 16);
    checkOutput("single_words", m_vcnt - s_v, 1);
    checkOutput("single_cs_low", m_cslow - s_c, 132);
    checkOutput("single_done_cnt", m_dcnt - s_d, 1);

    // Reset in the middle of SHIFT drops the word
    s_r = m_rises;
    applyStimulus(1'b0, 11'd1);
    n = 0;
    while (m_rises - s_r < 5 && n < 200) begin @(negedge clk); n++; end
    checkOutput("shift_reached", (m_rises - s_r >= 5), 1);
    rst_n = 1'b0;
    @(negedge clk);
    checkOutput("midrst_cs", m_cs, 1);
    checkOutput("midrst_sclk", m_sclk, 0);
    checkOutput("midrst_busy", m_busy, 0);
    rst_n = 1'b1;
    s_v = m_vcnt; s_d = m_dcnt;
    repeat (200) @(negedge clk);
    checkOutput("midrst_no_word", m_vcnt - s_v, 0);
    checkOutput("midrst_no_done", m_dcnt - s_d, 0);

    // Pacing: pixel_ready low between words
    m_base = 16'h1000 - m_idx;
    s_v = m_vcnt;
    applyStimulus(1'b0, 11'd2);
    n = 0;
    while (!m_valid && n < 300) begin @(negedge clk); n++; end
    checkOutput("pace_first_valid", m_valid, 1);
    checkOutput("pace_first_data", m_data, 16'h1000);
    m_ready = 1'b0;
    s_r = m_rises; s_c = m_cslow;
    repeat (500) @(negedge clk);
    checkOutput("pace_no_sclk", m_rises - s_r, 0);
    checkOutput("pace_cs_high", m_cslow - s_c, 0);
    checkOutput("pace_busy", m_busy, 1);
    checkOutput("pace_one_word", m_vcnt - s_v, 1);
    m_ready = 1'b1;
    n = 0;
    while (!m_done && n < 400) begin @(negedge clk); n++; end
    checkOutput("pace_done", m_done, 1);
    checkOutput("pace_two_words", m_vcnt - s_v, 2);
    checkOutput("pace_last_data", m_last, 16'h1001);

    // Abort mid-SHIFT of word 3 of 10
    @(negedge clk);
    m_base = 16'h0100 - m_idx;
    s_v = m_vcnt; s_r = m_rises; s_d = m_dcnt;
    applyStimulus(1'b0, 11'd10);
    n = 0;
    while (m_rises - s_r < 37 && n < 1000) begin @(negedge clk); n++; end
    checkOutput("abort_in_word3", m_vcnt - s_v, 2);
    m_abort = 1'b1;
    @(negedge clk);
    m_abort = 1'b0;
    n = 0;
    while (!m_done && n < 400) begin @(negedge clk); n++; end
    checkOutput("abort_done", m_done, 1);
    checkOutput("abort_words", m_vcnt - s_v, 3);
    checkOutput("abort_word3_data", m_last, 16'h0102);
    repeat (300) @(negedge clk);
    checkOutput("abort_no_word4", m_vcnt - s_v, 3);
    checkOutput("abort_done_cnt", m_dcnt - s_d, 1);
    checkOutput("abort_idle", m_busy, 0);

    // Timeout on the fast instance (TIMEOUT=100)
    f_ready = 1'b0;
    applyStimulus(1'b1, 11'd1);
    checkOutput("to_busy", f_busy, 1);
    n = 0;
    while (!f_err && n < 300) begin @(negedge clk); n++; end
    checkOutput("to_cycles", n, 100);
    checkOutput("to_err", f_err, 1);
    @(negedge clk);
    checkOutput("to_done", f_done, 1);
    checkOutput("to_busy_low", f_busy, 0);
    checkOutput("to_err_sticky", f_err, 1);
    f_ready = 1'b1;
    repeat (3) @(negedge clk);
    applyStimulus(1'b1, 11'd1);
    checkOutput("to_err_cleared", f_err, 0);
    n = 0;
    while (!f_done && n < 100) begin @(negedge clk); n++; end
    checkOutput("to_recover_done", f_done, 1);

    // Full frame: frame_len 0 means 2048 words
    @(negedge clk);
    s_v = f_vcnt; s_d = f_dcnt; s_o = f_ord_err;
    applyStimulus(1'b1, 11'd0);
    n = 0;
    while (!f_done && n < 60000) begin @(negedge clk); n++; end
    checkOutput("frame_done", f_done, 1);
    @(negedge clk);
    checkOutput("frame_words", f_vcnt - s_v, 2048);
    checkOutput("frame_order", f_ord_err - s_o, 0);
    checkOutput("frame_done_cnt", f_dcnt - s_d, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
